// File: rtl/uart_2bit_pkg.sv
// Shared definitions for the 2-bit UART receive/transmit pair:
// FSM state encoding, default bit timing and frame geometry.
package uart_2bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 576;  // 19200 baud
    localparam int unsigned HALF_BIT             = DEFAULT_CLKS_PER_BIT / 2;
    localparam int unsigned FRAME_LEN            = 4;    // start + 2 data + stop
    localparam int unsigned DATA_BITS            = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_2bit_rx_if.sv
// Receiver result bundle: the receiver drives it (master), consumers read it (slave).
interface uart_2bit_rx_if;

    logic [1:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    logic [7:0] err_cnt;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy,
        output err_cnt
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input rx_busy,
        input err_cnt
    );

endinterface

// File: rtl/uart_2bit_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic uart_rxd,
    output logic rxd_sync
);

    logic [1:0] sync_q;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rxd_sync = sync_q[1];

endmodule

// File: rtl/uart_2bit_rx.sv
// 2-data-bit UART receiver (1 start, 2 data LSB first, 1 stop, no parity).
// Define RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_2bit_rx
    import uart_2bit_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           sys_clk,
    input  logic           sys_reset,
    input  logic           uart_rxd,
    uart_2bit_rx_if.master rx_if
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);

`ifdef RX_MAJORITY_EN
    localparam int unsigned LATE = 1;
`else
    localparam int unsigned LATE = 0;
`endif

    // Decisions move one cycle late under majority voting; reloading the
    // counter with LATE keeps every later bit period at CLKS_PER_BIT cycles.
    localparam logic [CNT_W-1:0] START_HIT  = CNT_W'(CLKS_PER_BIT / 2 - 1 + LATE);
    localparam logic [CNT_W-1:0] BIT_HIT    = CNT_W'(CLKS_PER_BIT - 1 + LATE);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATE);

    logic             rxd_s;
    logic             line_bit;

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, cnt_nxt;
    logic             bit_idx, idx_nxt;
    logic [1:0]       shift_q, shift_nxt;
    logic [1:0]       rx_data_q, data_nxt;
    logic             rx_valid_q, valid_nxt;
    logic             frame_err_q, ferr_nxt;
    logic [7:0]       err_cnt_q;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .uart_rxd  (uart_rxd),
        .rxd_sync  (rxd_s)
    );

`ifdef RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign line_bit = maj3(hist_q[1], hist_q[0], rxd_s);
`else
    assign line_bit = rxd_s;
`endif

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= 1'b0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= cnt_nxt;
            bit_idx     <= idx_nxt;
            shift_q     <= shift_nxt;
            rx_data_q   <= data_nxt;
            rx_valid_q  <= valid_nxt;
            frame_err_q <= ferr_nxt;
            if (ferr_nxt && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt + CNT_W'(1);
        idx_nxt   = bit_idx;
        shift_nxt = shift_q;
        data_nxt  = rx_data_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // Start detection uses the raw synchronised edge, not the vote.
                cnt_nxt = '0;
                idx_nxt = 1'b0;
                if (!rxd_s) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (clk_cnt == START_HIT) begin
                    if (!line_bit) begin
                        state_nxt = DATA;
                        cnt_nxt   = CNT_RELOAD;
                        idx_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end

            DATA: begin
                if (clk_cnt == BIT_HIT) begin
                    shift_nxt[bit_idx] = line_bit;
                    cnt_nxt            = CNT_RELOAD;
                    if (bit_idx == 1'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end
            end

            STOP: begin
                if (clk_cnt == BIT_HIT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (line_bit) begin
                        data_nxt  = shift_q;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.rx_busy   = (state != IDLE);
    assign rx_if.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_2bit_rx.sv
// Directed bench for uart_2bit_rx: expected pulses are queued when a frame is
// driven and checked when rx_valid/frame_err fires. Honours RX_MAJORITY_EN.
module tb_uart_2bit_rx;

    localparam int unsigned C = 16;
    localparam int unsigned H = C / 2;
`ifdef RX_MAJORITY_EN
    localparam int unsigned MAJ = 1;
`else
    localparam int unsigned MAJ = 0;
`endif
    localparam int unsigned LAT_NOM = 2 + H + 3 * C + MAJ;

    typedef struct packed {
        logic       ferr;
        logic [1:0] data;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_reset = 1'b1;
    logic uart_rxd  = 1'b1;

    uart_2bit_rx_if rx_if ();

    uart_2bit_rx #(.CLKS_PER_BIT(C)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .uart_rxd  (uart_rxd),
        .rx_if     (rx_if)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned pulse_cnt      = 0;
    int unsigned last_pulse_cyc = 0;
    int unsigned prev_pulse_cyc = 0;
    int unsigned busy_cycles    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Drives one 4-bit frame from just after a rising edge; optional 1-cycle
    // inverted spike placed at the middle of d0.
    task automatic drive_frame(input logic d0, input logic d1, input logic stop,
                               input logic spike, output int unsigned t0);
        logic [3:0] bits;
        logic       b;
        bits = {stop, d1, d0, 1'b0};
        t0   = cyc;
        for (int i = 0; i < int'(4 * C); i++) begin
            b = bits[2'(i / int'(C))];
            if (spike && (i == int'(H + C))) b = ~b;
            uart_rxd = b;
            tick(1);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic wait_pulses(input string tag, input int unsigned target,
                               input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((pulse_cnt < target) && (n < budget)) begin
            tick(1);
            n++;
        end
        chk({"wait_", tag}, 32'(pulse_cnt >= target), 32'd1);
    endtask

    always @(negedge sys_clk) begin
        if (!sys_reset) begin
            if (rx_if.rx_busy) busy_cycles++;
            if (rx_if.rx_valid || rx_if.frame_err) begin
                chk("pulse_exclusive", 32'(rx_if.rx_valid & rx_if.frame_err), 32'd0);
                chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("pulse_kind_ferr", 32'(rx_if.frame_err), 32'(mon_e.ferr));
                    chk("pulse_data", 32'(rx_if.rx_data), 32'(mon_e.data));
                end
                prev_pulse_cyc = last_pulse_cyc;
                last_pulse_cyc = cyc;
                pulse_cnt++;
            end
        end
    end

    initial begin
        int unsigned t0, t1, base, lat;

        // Reset state
        sys_reset = 1'b1;
        uart_rxd  = 1'b1;
        tick(3);
        chk("rst_rx_data",   32'(rx_if.rx_data),   32'd0);
        chk("rst_rx_valid",  32'(rx_if.rx_valid),  32'd0);
        chk("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
        chk("rst_rx_busy",   32'(rx_if.rx_busy),   32'd0);
        chk("rst_err_cnt",   32'(rx_if.err_cnt),   32'd0);
        sys_reset = 1'b0;
        tick(5);

        // Single good frame 2'b01, latency
        base = pulse_cnt;
        sb.push_back('{ferr: 1'b0, data: 2'b01});
        drive_frame(1'b1, 1'b0, 1'b1, 1'b0, t0);
        wait_pulses("frame01", base + 1, 4 * C);
        lat = last_pulse_cyc - t0;
        chk("latency_min", 32'(lat + 1 >= LAT_NOM), 32'd1);
        chk("latency_max", 32'(lat <= LAT_NOM + 1), 32'd1);
        tick(2 * C);
        chk("single_pulse", pulse_cnt, base + 1);
        chk("frame01_data", 32'(rx_if.rx_data), 32'd1);
        chk("frame01_errcnt", 32'(rx_if.err_cnt), 32'd0);

        // Short low glitch on idle line
        base        = pulse_cnt;
        busy_cycles = 0;
        uart_rxd    = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(3 * C);
        chk("glitch_busy_min", 32'(busy_cycles + 1 >= H), 32'd1);
        chk("glitch_busy_max", 32'(busy_cycles <= H + 1 + MAJ), 32'd1);
        chk("glitch_no_pulse", pulse_cnt, base);
        chk("glitch_errcnt", 32'(rx_if.err_cnt), 32'd0);

        // Bad stop bit, then saturation of err_cnt
        base = pulse_cnt;
        for (int k = 0; k < 256; k++) begin
            sb.push_back('{ferr: 1'b1, data: 2'b01});
            drive_frame(1'b1, 1'b1, 1'b0, 1'b0, t0);
            tick(C);
            if (k == 0) begin
                chk("ferr_errcnt_1", 32'(rx_if.err_cnt), 32'd1);
                chk("ferr_data_held", 32'(rx_if.rx_data), 32'd1);
            end
        end
        chk("ferr_pulses", pulse_cnt, base + 256);
        chk("errcnt_saturated", 32'(rx_if.err_cnt), 32'd255);

        // Back-to-back frames 2'b10 then 2'b11
        base = pulse_cnt;
        sb.push_back('{ferr: 1'b0, data: 2'b10});
        sb.push_back('{ferr: 1'b0, data: 2'b11});
        drive_frame(1'b0, 1'b1, 1'b1, 1'b0, t0);
        drive_frame(1'b1, 1'b1, 1'b1, 1'b0, t1);
        wait_pulses("b2b", base + 2, 2 * C);
        chk("b2b_spacing", last_pulse_cyc - prev_pulse_cyc, 4 * C);
        tick(C);
        chk("b2b_last_data", 32'(rx_if.rx_data), 32'd3);

        // Reset in the middle of the first data bit
        base     = pulse_cnt;
        uart_rxd = 1'b0;
        tick(C);
        uart_rxd = 1'b1;
        tick(H);
        chk("midframe_busy", 32'(rx_if.rx_busy), 32'd1);
        sys_reset = 1'b1;
        #1;
        chk("midrst_rx_data", 32'(rx_if.rx_data), 32'd0);
        chk("midrst_rx_busy", 32'(rx_if.rx_busy), 32'd0);
        chk("midrst_err_cnt", 32'(rx_if.err_cnt), 32'd0);
        tick(3);
        sys_reset = 1'b0;
        tick(2 * C);
        chk("aborted_no_pulse", pulse_cnt, base);
        sb.push_back('{ferr: 1'b0, data: 2'b11});
        drive_frame(1'b1, 1'b1, 1'b1, 1'b0, t0);
        wait_pulses("after_rst", base + 1, 4 * C);
        tick(C);
        chk("after_rst_data", 32'(rx_if.rx_data), 32'd3);

        // One-cycle spike at mid d0
        base = pulse_cnt;
        sb.push_back('{ferr: 1'b0, data: (MAJ != 0) ? 2'b11 : 2'b10});
        drive_frame(1'b1, 1'b1, 1'b1, 1'b1, t0);
        wait_pulses("spike", base + 1, 4 * C);
        tick(C);
        chk("spike_data", 32'(rx_if.rx_data), (MAJ != 0) ? 32'd3 : 32'd2);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_2bit_rx.md
UART_2BIT_RX -- requirements
Module: uart_2bit_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 576, sys_clk cycles per bit (19200 baud).
REQ-002 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port uart_rxd  input  1  serial line, asynchronous to sys_clk, idle high.
REQ-005 SHALL have port rx_data  output  2  last good frame; bit0 = first data bit (in1), bit1 = second (in2).
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-008 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have port err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-010 SHALL synchronise uart_rxd through two flops, reset value 1; the FSM sees the synchronised line only.
REQ-011 SHALL support frame format: 1 start bit (0), 2 data bits (LSB first), 1 stop bit (1); no parity.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-013 IDLE: on synchronised line = 0, SHALL go to START with bit counter clk_cnt = 0.
REQ-014 START: at clk_cnt = CLKS_PER_BIT/2 - 1, SHALL sample; line 0 -> DATA (clk_cnt = 0, bit_idx = 0); line 1 -> IDLE, glitch rejected, no error, no pulse.
REQ-015 DATA: at clk_cnt = CLKS_PER_BIT - 1, SHALL sample into shift[bit_idx]; after bit_idx 1 -> STOP; clk_cnt wraps to 0 each bit.
REQ-016 STOP: at clk_cnt = CLKS_PER_BIT - 1, SHALL sample; 1 -> rx_data <= shift, rx_valid = 1 for one cycle; 0 -> frame_err = 1 for one cycle, rx_data held.
REQ-017 STOP SHALL return to IDLE in the same cycle it samples, so a start edge one bit-time later is accepted (back-to-back frames).
REQ-018 rx_valid and frame_err SHALL never be high together.
REQ-019 err_cnt SHALL increment on each frame_err; it SHALL saturate at 255 and not wrap.
REQ-020 Latency: rx_valid SHALL assert (2 + CLKS_PER_BIT/2 + 3*CLKS_PER_BIT) cycles +/-1 after the start-bit falling edge at uart_rxd.

Reset
REQ-021 sys_reset SHALL force rx_data = 2'b00, rx_valid = 0, frame_err = 0, rx_busy = 0, err_cnt = 0, FSM IDLE, counters 0, sync flops 1.
REQ-022 Reset mid-frame SHALL abandon the frame with no pulse; after release, the next start bit SHALL be received normally.

Configuration
REQ-023 With RX_MAJORITY_EN defined, each sample point SHALL use a 2-of-3 majority of the line at clk_cnt = target-1, target, target+1; the decision and transition SHALL occur at target+1. Without it, a single sample at target SHALL be used. Latency (REQ-020) SHALL grow by 1 cycle when enabled.

Structure
REQ-024 Package uart_2bit_pkg SHALL hold the FSM state enum, default CLKS_PER_BIT = 576, HALF_BIT = 288, and frame length constant 4; it SHALL be shared with the TX block.
REQ-025 The two-flop synchroniser SHALL be sub-module uart_rx_sync (reset value 1).

Verification
REQ-026 Frame start 0, d0 = 1, d1 = 0, stop 1 at 576 clk/bit -> rx_data = 2'b01, single rx_valid pulse at latency per REQ-020, err_cnt = 0.
REQ-027 100-cycle low glitch on idle line -> START aborts to IDLE; no rx_valid or frame_err; rx_busy high for about 290 cycles only.
REQ-028 Frame 0,1,1 with stop = 0 -> frame_err pulse, rx_data keeps previous value, err_cnt = 1; 256 such frames -> err_cnt = 255.
REQ-029 Back-to-back frames 2'b10 then 2'b11 with no idle gap -> two rx_valid pulses exactly 4*576 cycles apart, values 10 then 11.
REQ-030 sys_reset asserted during DATA, then a frame 2'b11 -> no pulse for the aborted frame; rx_data = 2'b11 after the new frame.
REQ-031 With RX_MAJORITY_EN: 1-cycle inverted spike on d0 exactly at mid-bit -> rx_data correct; without the macro, the same stimulus -> d0 flipped.
